led_div_ctrl: RTL and testbench

LED_DIV_CTRL -- requirements
Module: led_div_ctrl

---
 rtl/led_pkg.sv | 33 +++
 rtl/btn_debounce.sv | 92 +++++++++
 rtl/led_div_ctrl.sv | 72 +++++++
 tb/tb_led_div_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// ============================================================================
// Module  : led_pkg
// Brief   : Shared constants, debounce state type and divider step helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package led_pkg;

    localparam int unsigned       DIV_W    = 5;
    localparam logic [DIV_W-1:0]  DIV_MAX  = 5'h14;
    localparam logic [27:0]       CNT_1S   = 28'h5F5E100;
    localparam int unsigned       DB_CNT_W = 24;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CNT   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CNT = 2'd3
    } db_state_e;

    // Wrapping step over the legal range 1..DIV_MAX.
    function automatic logic [DIV_W-1:0] div_step(input logic [DIV_W-1:0] cur,
                                                  input logic             up);
        if (up) begin
            return (cur >= DIV_MAX) ? 5'd1 : cur + 5'd1;
        end
        return (cur <= 5'd1) ? DIV_MAX : cur - 5'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module  : btn_debounce
// Brief   : 2-flop synchronizer plus counting debounce FSM; one-cycle press_o.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce
    import led_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk100,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                sync1_q;
    logic                sync2_q;
    db_state_e           state_q;
    db_state_e           state_d;
    logic [DB_CNT_W-1:0] cnt_q;
    logic [DB_CNT_W-1:0] cnt_d;

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= RELEASED;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter only advances below CNT_LAST; reaching it always leaves the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_o = 1'b0;
        case (state_q)
            RELEASED: begin
                if (sync2_q) begin
                    state_d = PRESS_CNT;
                    cnt_d   = '0;
                end
            end
            PRESS_CNT: begin
                if (!sync2_q) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press_o = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!sync2_q) begin
                    state_d = RELEASE_CNT;
                    cnt_d   = '0;
                end
            end
            RELEASE_CNT: begin
                if (sync2_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/led_div_ctrl.sv
// ============================================================================
// Module  : led_div_ctrl
// Brief   : Up/down pushbuttons step a wrapping LED blink divider with a write pulse.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module led_div_ctrl
    import led_pkg::*;
#(
    parameter int unsigned       DEBOUNCE_CYCLES = 1000000,
    parameter logic [DIV_W-1:0]  DIV_INIT        = 5'h1
) (
    input  logic             clk100,
    input  logic             rst_n,
    input  logic             btn_up_i,
    input  logic             btn_dn_i,
    output logic [DIV_W-1:0] div_o,
    output logic             wren_o
);

    logic             up_press;
    logic             dn_press;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             wren_q;
    logic             wren_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_up (
        .clk100  (clk100),
        .rst_n   (rst_n),
        .btn_i   (btn_up_i),
        .press_o (up_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_dn (
        .clk100  (clk100),
        .rst_n   (rst_n),
        .btn_i   (btn_dn_i),
        .press_o (dn_press)
    );

    // Simultaneous presses cancel: no update and no write pulse.
    always_comb begin
        div_d  = div_q;
        wren_d = 1'b0;
        if (up_press ^ dn_press) begin
            div_d  = div_step(div_q, up_press);
            wren_d = 1'b1;
        end
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= DIV_INIT;
            wren_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            wren_q <= wren_d;
        end
    end

    assign div_o  = div_q;
    assign wren_o = wren_q;

endmodule

`default_nettype wire

// File: tb/tb_led_div_ctrl.sv
// ============================================================================
// Module  : tb_led_div_ctrl
// Brief   : Directed stimulus against a run-length debounce model of led_div_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_div_ctrl;

    localparam int unsigned DB      = 8;
    localparam int          RUN_MAX = DB + 1;  // consecutive synced samples needed to flip level

    logic       clk100   = 1'b0;
    logic       rst_n    = 1'b0;
    logic       btn_up_i = 1'b0;
    logic       btn_dn_i = 1'b0;
    logic [4:0] div_o;
    logic       wren_o;

    int vectors       = 0;
    int miscompares   = 0;
    int cyc           = 0;
    int pulses        = 0;
    int last_wren_cyc = -1;

    int m_div  = 1;
    bit m_wren = 1'b0;
    bit uh1, uh2, dh1, dh2;
    bit lvl[2];
    int run[2];

    always #5 clk100 = ~clk100;

    led_div_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .DIV_INIT        (5'h1)
    ) dut (
        .clk100   (clk100),
        .rst_n    (rst_n),
        .btn_up_i (btn_up_i),
        .btn_dn_i (btn_dn_i),
        .div_o    (div_o),
        .wren_o   (wren_o)
    );

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A button's accepted level flips after RUN_MAX consecutive synced samples at the other level.
    task automatic db_step(input int b, input bit y, output bit p);
        p = 1'b0;
        if (y != lvl[b]) run[b]++;
        else             run[b] = 0;
        if (run[b] == RUN_MAX) begin
            lvl[b] = y;
            run[b] = 0;
            p      = y;
        end
    endtask

    initial begin
        bit yu, yd, pu, pd;
        forever begin
            @(negedge clk100);
            cyc++;
            if (!rst_n) begin
                m_div  = 1;
                m_wren = 1'b0;
                uh1 = 0; uh2 = 0; dh1 = 0; dh2 = 0;
                lvl[0] = 0; lvl[1] = 0; run[0] = 0; run[1] = 0;
            end else begin
                yu = uh2; uh2 = uh1; uh1 = btn_up_i;
                yd = dh2; dh2 = dh1; dh1 = btn_dn_i;
                db_step(0, yu, pu);
                db_step(1, yd, pd);
                m_wren = pu ^ pd;
                if (pu && !pd)      m_div = (m_div == 20) ? 1 : m_div + 1;
                else if (pd && !pu) m_div = (m_div == 1) ? 20 : m_div - 1;
            end
            chk("div_o", int'(div_o), m_div);
            chk("wren_o", int'(wren_o), int'(m_wren));
            if (wren_o === 1'b1) begin
                pulses++;
                last_wren_cyc = cyc;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk100);
    endtask

    task automatic drive(input bit up, input bit dn);
        @(negedge clk100);
        #1;
        btn_up_i = up;
        btn_dn_i = dn;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk100);
        #1 rst_n = 1'b0;
        repeat (n) @(negedge clk100);
        #1 rst_n = 1'b1;
    endtask

    task automatic press(input bit up, input bit dn);
        drive(up, dn);
        idle(15);
        drive(1'b0, 1'b0);
        idle(15);
    endtask

    initial begin
        int p0, c0;

        // Reset state, then 100 idle cycles
        repeat (3) @(negedge clk100);
        #2;
        chk("reset_div", int'(div_o), 1);
        chk("reset_wren", int'(wren_o), 0);
        rst_n = 1'b1;
        p0 = pulses;
        idle(100);
        chk("idle_pulses", pulses - p0, 0);
        chk("idle_div", int'(div_o), 1);

        // Held up press: one pulse DB+3 cycles after the button rises
        drive(1'b1, 1'b0);
        c0 = cyc; p0 = pulses;
        idle(20);
        drive(1'b0, 1'b0);
        idle(20);
        chk("up_pulses", pulses - p0, 1);
        chk("up_latency", last_wren_cyc - c0, 11);
        chk("up_div", int'(div_o), 2);

        // Bouncing input never accepted, clean press afterwards is
        do_reset(2);
        p0 = pulses;
        for (int i = 0; i < 20; i++) begin
            drive((i % 2) == 0, 1'b0);
            idle(2);
        end
        drive(1'b0, 1'b0);
        idle(12);
        chk("bounce_pulses", pulses - p0, 0);
        chk("bounce_div", int'(div_o), 1);
        press(1'b1, 1'b0);
        chk("clean_div", int'(div_o), 2);
        chk("clean_pulses", pulses - p0, 1);

        // Wrap in both directions
        do_reset(2);
        p0 = pulses;
        press(1'b0, 1'b1);
        chk("wrap_dn_div", int'(div_o), 20);
        press(1'b1, 1'b0);
        chk("wrap_up_div", int'(div_o), 1);
        press(1'b0, 1'b1);
        chk("wrap_dn2_div", int'(div_o), 20);
        chk("wrap_pulses", pulses - p0, 3);

        // Simultaneous presses cancel; staggered presses both land
        p0 = pulses;
        press(1'b1, 1'b1);
        chk("both_pulses", pulses - p0, 0);
        chk("both_div", int'(div_o), 20);
        p0 = pulses;
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        idle(15);
        drive(1'b0, 1'b0);
        idle(15);
        chk("stagger_pulses", pulses - p0, 2);
        chk("stagger_div", int'(div_o), 20);

        // Reset mid-count with the button held through it
        drive(1'b1, 1'b0);
        idle(7);
        @(negedge clk100);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_div", int'(div_o), 1);
        chk("midrst_wren", int'(wren_o), 0);
        repeat (3) @(negedge clk100);
        #1 rst_n = 1'b1;
        c0 = cyc; p0 = pulses;
        idle(20);
        chk("midrst_pulses", pulses - p0, 1);
        chk("midrst_latency", last_wren_cyc - c0, 11);
        chk("midrst_div2", int'(div_o), 2);
        drive(1'b0, 1'b0);
        idle(15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
